// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU opcodes and forwarding-source encoding.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  // Where an operand's value comes from this cycle.
  typedef enum logic [1:0] {
    FWD_REG      = 2'd0,
    FWD_EX       = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding mux for one source operand: EX beats MEM beats register file,
// and register 0 is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic [W-1:0]  q,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [RW-1:0] ex_rn,
  input  logic [W-1:0]  ex_s,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [RW-1:0] mem_rn,
  input  logic [W-1:0]  mem_alu,
  input  logic [W-1:0]  mem_mdata,
  output logic [W-1:0]  data
);

  fwd_sel_e sel;

  // Source priority. A load in EX has no data yet, so it is not a forwarding
  // source; the hazard logic stalls instead.
  always_comb begin
    sel = FWD_REG;
    if (ex_wreg && !ex_m2reg && (ex_rn != '0) && (ex_rn == rs))
      sel = FWD_EX;
    else if (mem_wreg && (mem_rn != '0) && (mem_rn == rs))
      sel = mem_m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
  end

  // Data select for the chosen source.
  always_comb begin
    case (sel)
      FWD_EX:       data = ex_s;
      FWD_MEM_ALU:  data = mem_alu;
      FWD_MEM_LOAD: data = mem_mdata;
      default:      data = q;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use
// stall detection and flush handling.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [3:0]    id_aluc,
  input  logic          id_shift,
  input  logic          id_aluimm,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic          id_usea,
  input  logic          id_useb,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rn,
  input  logic [W-1:0]  id_qa,
  input  logic [W-1:0]  id_qb,
  input  logic [W-1:0]  id_imm,
  input  logic [4:0]    id_sa,
  input  logic          flush,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [RW-1:0] ex_rn,
  input  logic [W-1:0]  ex_s,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [RW-1:0] mem_rn,
  input  logic [W-1:0]  mem_alu,
  input  logic [W-1:0]  mem_mdata,
  output logic          stall,
  output logic [W-1:0]  ea,
  output logic [W-1:0]  eb,
  output logic [3:0]    ealuc,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          evalid,
  output logic [RW-1:0] ern,
  output logic [W-1:0]  estore
);

  logic [W-1:0] fa, fb;
  logic         load;

  fwd_mux #(.W(W), .RW(RW)) u_fwd_a (
    .rs(id_rs), .q(id_qa),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_s(ex_s),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .mem_alu(mem_alu), .mem_mdata(mem_mdata),
    .data(fa)
  );

  fwd_mux #(.W(W), .RW(RW)) u_fwd_b (
    .rs(id_rt), .q(id_qb),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_s(ex_s),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .mem_alu(mem_alu), .mem_mdata(mem_mdata),
    .data(fb)
  );

  // Load-use hazard: a load in EX targets a register this instruction reads.
  // Flush suppresses it since the instruction is being killed anyway.
  always_comb begin
    stall = id_valid && !flush && ex_wreg && ex_m2reg && (ex_rn != '0) &&
            ((id_usea && (ex_rn == id_rs)) || (id_useb && (ex_rn == id_rt)));
  end

  assign load = id_valid && !flush && !stall;

  // Pipeline register: capture the instruction or load a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evalid <= 1'b0;
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      ewmem  <= 1'b0;
      ealuc  <= ALU_ADD;
      ern    <= '0;
      ea     <= '0;
      eb     <= '0;
      estore <= '0;
    end else if (load) begin
      evalid <= 1'b1;
      ewreg  <= id_wreg;
      em2reg <= id_m2reg;
      ewmem  <= id_wmem;
      ealuc  <= id_aluc;
      ern    <= id_rn;
      ea     <= id_shift ? {{(W-5){1'b0}}, id_sa} : fa;
      eb     <= id_aluimm ? id_imm : fb;
      estore <= fb;
    end else begin
      evalid <= 1'b0;
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      ewmem  <= 1'b0;
      ealuc  <= ALU_ADD;
      ern    <= '0;
      ea     <= '0;
      eb     <= '0;
      estore <= '0;
    end
  end

endmodule
